// File: rtl/johnson_pkg.sv
// Shared helpers for the Johnson counter phase tracker.
// Phase width and modular phase advance used by decode and top.
package johnson_pkg;

  function automatic int phase_width(input int n);
    return $clog2(2 * n);
  endfunction

  function automatic int jc_next_phase(input int p, input int n);
    return (p + 1) % (2 * n);
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code to binary phase decoder.
// Flags any code outside the 2N legal patterns.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = phase_width(N)
) (
  input  logic [N-1:0]  i_jc,
  output logic [PW-1:0] o_phase,
  output logic          o_legal
);

  localparam logic [N-1:0] ONES = '1;

  logic [N-1:0] w_code;

  // Phases 0..N fill ones from the top; later phases drain them.
  always_comb begin
    o_phase = '0;
    o_legal = 1'b0;
    w_code  = '0;
    for (int p = 0; p < 2 * N; p++) begin
      if (p <= N) begin
        w_code = ~(ONES >> p);
      end else begin
        w_code = ONES >> (p - N);
      end
      if (i_jc == w_code) begin
        o_phase = PW'(p);
        o_legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/johnson_phase_tracker.sv
// Monitors a Johnson counter: decodes phase, checks advance,
// and reports step/hold pulses plus illegal/skip errors.
module johnson_phase_tracker
  import johnson_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int ERRW = 8,
  localparam int PW   = phase_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    i_jc_in,
  input  logic            i_err_clr,
  output logic [PW-1:0]   o_phase,
  output logic [2*N-1:0]  o_phase_oh,
  output logic            o_legal,
  output logic            o_step,
  output logic            o_hold,
  output logic            o_err_illegal,
  output logic            o_err_skip,
  output logic            o_err_sticky,
  output logic [ERRW-1:0] o_err_cnt
);

  localparam logic [ERRW-1:0] CNT_MAX = '1;

  logic [PW-1:0]   w_dec_phase;
  logic            w_dec_legal;
  logic [PW-1:0]   w_nxt_phase;
  logic            w_step;
  logic            w_hold;
  logic            w_skip;
  logic            w_err;
  logic [ERRW-1:0] w_cnt_base;
  logic [ERRW-1:0] w_cnt_nxt;
  logic            w_sticky_nxt;
  logic [2*N-1:0]  w_oh;

  logic [PW-1:0]   r_phase;
  logic            r_legal;
  logic            r_primed;
  logic            r_step;
  logic            r_hold;
  logic            r_err_illegal;
  logic            r_err_skip;
  logic            r_err_sticky;
  logic [ERRW-1:0] r_err_cnt;

  johnson_decode #(.N(N)) u_decode (
    .i_jc    (i_jc_in),
    .o_phase (w_dec_phase),
    .o_legal (w_dec_legal)
  );

  // r_phase always holds the last legal phase, so it is the reference.
  assign w_nxt_phase = PW'(jc_next_phase(int'(r_phase), N));

  assign w_step = w_dec_legal & r_primed &
                  (w_dec_phase == w_nxt_phase);
  assign w_hold = w_dec_legal & r_primed &
                  (w_dec_phase == r_phase);
  assign w_skip = w_dec_legal & r_primed &
                  ~w_step & ~w_hold;
  assign w_err  = ~w_dec_legal | w_skip;

  // Clear first, then count this cycle's error.
  assign w_cnt_base = i_err_clr ? '0 : r_err_cnt;
  assign w_cnt_nxt  = (w_err && (w_cnt_base != CNT_MAX)) ?
                      w_cnt_base + 1'b1 : w_cnt_base;
  assign w_sticky_nxt = (~i_err_clr & r_err_sticky) | w_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase       <= '0;
      r_legal       <= 1'b0;
      r_primed      <= 1'b0;
      r_step        <= 1'b0;
      r_hold        <= 1'b0;
      r_err_illegal <= 1'b0;
      r_err_skip    <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      if (w_dec_legal) begin
        r_phase <= w_dec_phase;
      end
      r_legal       <= w_dec_legal;
      r_primed      <= w_dec_legal;
      r_step        <= w_step;
      r_hold        <= w_hold;
      r_err_illegal <= ~w_dec_legal;
      r_err_skip    <= w_skip;
      r_err_sticky  <= w_sticky_nxt;
      r_err_cnt     <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_oh          = '0;
    w_oh[r_phase] = r_legal;
  end

  assign o_phase       = r_phase;
  assign o_phase_oh    = w_oh;
  assign o_legal       = r_legal;
  assign o_step        = r_step;
  assign o_hold        = r_hold;
  assign o_err_illegal = r_err_illegal;
  assign o_err_skip    = r_err_skip;
  assign o_err_sticky  = r_err_sticky;
  assign o_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Scoreboard bench for johnson_phase_tracker (N=4, ERRW=2).
// Driver pushes model results; monitor pops and compares.
module tb_johnson_phase_tracker;

  localparam int N    = 4;
  localparam int ERRW = 2;
  localparam int PH   = 2 * N;
  localparam int CMAX = (1 << ERRW) - 1;

  typedef struct packed {
    logic [2:0]      phase;
    logic [PH-1:0]   oh;
    logic            legal;
    logic            step;
    logic            hold;
    logic            ill;
    logic            skip;
    logic            sticky;
    logic [ERRW-1:0] cnt;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [N-1:0]    jc;
  logic            clr;
  logic [2:0]      phase;
  logic [PH-1:0]   phase_oh;
  logic            legal;
  logic            step;
  logic            hold;
  logic            err_ill;
  logic            err_skip;
  logic            err_sticky;
  logic [ERRW-1:0] err_cnt;

  johnson_phase_tracker #(.N(N), .ERRW(ERRW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_jc_in       (jc),
    .i_err_clr     (clr),
    .o_phase       (phase),
    .o_phase_oh    (phase_oh),
    .o_legal       (legal),
    .o_step        (step),
    .o_hold        (hold),
    .o_err_illegal (err_ill),
    .o_err_skip    (err_skip),
    .o_err_sticky  (err_sticky),
    .o_err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] codes [PH];
  exp_t q [$];
  int n_chk;
  int n_fail;

  int m_phase;
  bit m_primed;
  int m_cnt;
  bit m_sticky;
  int cidx;

  function automatic int find_code(input logic [N-1:0] c);
    for (int i = 0; i < PH; i++)
      if (codes[i] == c) return i;
    return -1;
  endfunction

  task automatic drive(input bit r, input logic [N-1:0] c,
                       input bit cl);
    exp_t e;
    int p;
    bit err;
    @(negedge clk);
    rst = r;
    jc  = c;
    clr = cl;
    e = '0;
    if (r) begin
      m_phase  = 0;
      m_primed = 0;
      m_cnt    = 0;
      m_sticky = 0;
    end else begin
      p = find_code(c);
      if (p >= 0) begin
        e.legal = 1'b1;
        e.step  = m_primed && (p == (m_phase + 1) % PH);
        e.hold  = m_primed && (p == m_phase);
        e.skip  = m_primed && !e.step && !e.hold;
        m_phase = p;
        m_primed = 1;
        e.oh = PH'(1) << p;
      end else begin
        e.ill = 1'b1;
        m_primed = 0;
      end
      err = e.ill | e.skip;
      if (cl) begin
        m_cnt = 0;
        m_sticky = 0;
      end
      if (err) begin
        m_sticky = 1;
        if (m_cnt < CMAX) m_cnt++;
      end
      e.phase  = 3'(m_phase);
      e.sticky = m_sticky;
      e.cnt    = ERRW'(m_cnt);
    end
    q.push_back(e);
  endtask

  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{phase, phase_oh, legal, step, hold,
              err_ill, err_skip, err_sticky, err_cnt};
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t got ph=%0d oh=%b lg=%b st=%b ho=%b il=%b sk=%b sy=%b cn=%0d want ph=%0d oh=%b lg=%b st=%b ho=%b il=%b sk=%b sy=%b cn=%0d",
            $time, a.phase, a.oh, a.legal, a.step, a.hold, a.ill,
            a.skip, a.sticky, a.cnt, e.phase, e.oh, e.legal,
            e.step, e.hold, e.ill, e.skip, e.sticky, e.cnt);
        end
      end
    end
  end

  initial begin
    int r;
    codes = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
              4'b1111, 4'b0111, 4'b0011, 4'b0001};
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    jc  = '0;
    clr = 1'b0;
    drive(1, 4'b0001, 0);
    drive(1, 4'b0001, 0);
    cidx = 7;
    for (int i = 0; i < 12; i++) begin
      drive(0, codes[cidx], 0);
      cidx = (cidx + 1) % PH;
    end
    drive(0, 4'b0001, 0);
    drive(0, 4'b0000, 0);
    drive(0, 4'b0101, 0);
    drive(0, 4'b1100, 0);
    drive(0, 4'b1000, 0);
    drive(0, 4'b1110, 0);
    drive(0, 4'b1110, 0);
    for (int i = 0; i < 5; i++) drive(0, 4'b1010, 0);
    drive(0, 4'b1011, 1);
    drive(0, 4'b0011, 1);
    drive(0, 4'b0001, 0);
    drive(0, 4'b1111, 0);
    drive(0, 4'b0111, 0);
    drive(1, 4'b0011, 0);
    drive(0, 4'b1111, 0);
    drive(0, 4'b0111, 0);
    cidx = 5;
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(99);
      if (r < 70)      cidx = (cidx + 1) % PH;
      else if (r < 80) cidx = cidx;
      else if (r < 90) cidx = $urandom_range(PH - 1);
      if (r >= 90 && r < 97)
        drive(0, 4'($urandom), $urandom_range(9) == 0);
      else
        drive(r >= 97, codes[cidx], $urandom_range(9) == 0);
    end
    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got %0d left want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/johnson_phase_tracker.md
# johnson_phase_tracker

Downstream monitor for the N-bit Johnson counter. It samples the counter's Q bus every clock and decodes the code into a binary phase index and a one-hot phase vector. It checks that each code is legal and that successive codes advance by exactly one phase, and it reports step pulses, error pulses, a sticky error flag and a saturating error count. Phase-sequenced logic consumes the outputs in place of raw Johnson bits.

## Interface
- N, 4: Johnson width; N ≥ 2; the counter has 2N phases.
- ERRW, 8: error counter width.
- PW, $clog2(2N) (derived, not overridable): phase index width.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- jc_in  in  N  Johnson code, driven directly from the counter Q.
- err_clr  in  1  clears err_cnt and err_sticky.
- phase  out  PW  binary phase index of the last legal code.
- phase_oh  out  2N  one-hot phase; all zeros when the current sample is illegal.
- legal  out  1  current sample is a legal Johnson code.
- step  out  1  pulse: sample advanced exactly +1 phase, modulo 2N.
- hold  out  1  pulse: sample equals the previous phase.
- err_illegal  out  1  pulse: sample not in the legal set.
- err_skip  out  1  pulse: legal sample that is neither +0 nor +1 from the previous phase.
- err_sticky  out  1  set by any error; cleared only by rst or err_clr.
- err_cnt  out  ERRW  saturating count of error cycles.

## Operation
- Phase map, with counter shift order Q[N-1] <= ~Q[0] and Q[i] <= Q[i+1]:
  - p = 0..N: the top p bits are 1, the rest 0.
  - p = N+1..2N-1: the bottom 2N−p bits are 1, the rest 0.
  - Example N=4: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7.
  - The counter's reset value 1 maps to phase 2N−1.
- Every other code is illegal.
- primed flag (internal): set by a legal sample, cleared by rst and by any illegal sample.
- Legal sample, primed=0:
  - phase and phase_oh update; legal=1.
  - No step, hold or skip check; primed becomes 1.
- Legal sample, primed=1, previous phase pp, new phase p:
  - p == (pp+1) mod 2N → step=1.
  - p == pp → hold=1.
  - Otherwise → err_skip=1.
  - In every case, phase and phase_oh update to p.
- Illegal sample:
  - err_illegal=1, legal=0, phase_oh=0.
  - phase holds its last legal value; primed clears.
- Wrap: a transition from phase 2N−1 to phase 0 is a normal step, not a skip.
- err_illegal and err_skip are mutually exclusive. Each error cycle sets err_sticky and increments err_cnt by 1.
- err_cnt saturates at 2^ERRW−1 and never wraps.
- err_clr with no error in the same cycle: err_cnt=0, err_sticky=0 next cycle.
- err_clr in the same cycle as an error: the clear applies first, then the error counts, giving err_cnt=1 and err_sticky=1.

## Timing
- All outputs are registered. Latency is 1 cycle: the response to the jc_in sampled at edge k appears after edge k.
- Pulse outputs (step, hold, err_illegal, err_skip) are high for exactly the one cycle after the triggering sample.
- Reset values: phase=0, phase_oh=0, legal=0, step=0, hold=0, err_illegal=0, err_skip=0, err_sticky=0, err_cnt=0, primed=0.
- Reset mid-stream: all state returns to the reset values on the next edge. The first sample after rst deasserts is treated as unprimed, so no skip is flagged.
- err_clr has no effect on phase, phase_oh, legal or primed.

## Structure
- Shared package johnson_pkg holds:
  - the function phase_width(N) returning $clog2(2N);
  - the function jc_next_phase(p, N) returning (p+1) mod 2N.
- Sub-module johnson_decode: purely combinational; input jc[N-1:0]; outputs phase[PW-1:0] and legal. Instantiated once.
- The top level holds the primed flag, the previous-phase register, the compare logic and the error counter.
- The 2N-bit one-hot vector is generated from the registered phase, gated by legal.

## Test plan
- Basic stepping (N=4): release rst with the counter feeding jc_in. The sequence 0001, 0000, 1000, … yields phase 7, 0, 1, …. step=1 from the second sample onward; no errors.
- Wrap: 0001 followed by 0000 → step=1, phase 7→0, err_skip=0.
- Illegal code: 0101 injected → err_illegal=1 for one cycle, legal=0, phase_oh=0, phase holds, err_cnt=1. The next legal code 1100 → phase=2 with no skip flagged.
- Skip and hold: 1000 then 1110 → err_skip=1, phase=3. Then 1110 again → hold=1.
- Saturation and clear (ERRW=2): 5 consecutive illegal codes → err_cnt holds at 3. err_clr together with one further illegal code → err_cnt=1, err_sticky=1. err_clr alone → both cleared.
- Reset mid-stream: assert rst at phase 5 → all outputs at reset values the next cycle. Release rst and apply 1111 → phase=4, no skip flagged.
